// File: rtl/circular_pointer_fifo_gen_pkg.sv
// Shared helpers for the circular-pointer FIFO: width derivation and the
// wrap-aware pointer increment used by every pointer register.
package cpf_pkg;

  localparam int CPF_MIN_DEPTH = 2;

  // A depth-1 FIFO would give $clog2 = 0; keep pointers at least one bit wide.
  function automatic int cpf_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cpf_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [31:0] cpf_wrap_inc(input logic [31:0] ptr,
                                               input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/circular_pointer_fifo_gen_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface circular_pointer_fifo_gen_if
  import cpf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
);
  localparam int CNTW = cpf_cnt_width(DEPTH);

  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNTW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, pop, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, push, pop, data_in,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/circular_pointer_fifo_gen_ptr.sv
// Wrapping pointer register cpf_ptr: counts 0..DEPTH-1 with an explicit
// compare, so non-power-of-2 depths wrap correctly.
module cpf_ptr
  import cpf_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int PTRW  = cpf_ptr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [PTRW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PTRW'(cpf_wrap_inc(32'(ptr), 32'(DEPTH)));
    end
  end

endmodule

// File: rtl/circular_pointer_fifo_gen.sv
// Single-clock circular-pointer FIFO with arbitrary depth, protected push/pop,
// thresholds and flush. Optional sticky error flags: define CPF_ERR_FLAGS_EN.
module circular_pointer_fifo_gen
  import cpf_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 6,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic clk,
  input  logic rst,
  circular_pointer_fifo_gen_if.slave bus
);

  localparam int PTRW = cpf_ptr_width(DEPTH);
  localparam int CNTW = cpf_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count_q;
  logic             full_w;
  logic             empty_w;
  logic             push_acc;
  logic             pop_acc;

  assign full_w  = (count_q == CNTW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A push at full only lands when a pop frees the head slot in the same cycle.
  assign push_acc = bus.push & (~full_w | bus.pop) & ~bus.flush;
  assign pop_acc  = bus.pop & ~empty_w & ~bus.flush;

  cpf_ptr #(.DEPTH(DEPTH), .PTRW(PTRW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (push_acc),
    .ptr (wr_ptr)
  );

  cpf_ptr #(.DEPTH(DEPTH), .PTRW(PTRW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNTW'(push_acc) - CNTW'(pop_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out     = mem[rd_ptr];
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CNTW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNTW'(AE_LEVEL));

`ifdef CPF_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && full_w && !bus.pop) overflow_q  <= 1'b1;
      if (bus.pop && empty_w)             underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_circular_pointer_fifo_gen.sv
// Directed bench for circular_pointer_fifo_gen: three instances (depths 5, 4, 6)
// exercise wrap, full/empty protection, thresholds, flush and reset.
module tb_circular_pointer_fifo_gen;

`ifdef CPF_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  circular_pointer_fifo_gen_if #(.WIDTH(8), .DEPTH(5)) f5 ();
  circular_pointer_fifo_gen_if #(.WIDTH(8), .DEPTH(4)) f4 ();
  circular_pointer_fifo_gen_if #(.WIDTH(8), .DEPTH(6)) f6 ();

  circular_pointer_fifo_gen #(.WIDTH(8), .DEPTH(5)) u_f5 (.clk(clk), .rst(rst), .bus(f5));
  circular_pointer_fifo_gen #(.WIDTH(8), .DEPTH(4)) u_f4 (.clk(clk), .rst(rst), .bus(f4));
  circular_pointer_fifo_gen #(.WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1))
    u_f6 (.clk(clk), .rst(rst), .bus(f6));

  task automatic op5(input logic pu, input logic po, input logic [7:0] d);
    @(negedge clk); f5.push = pu; f5.pop = po; f5.data_in = d;
    @(posedge clk); #1; f5.push = 1'b0; f5.pop = 1'b0;
  endtask

  task automatic op4(input logic pu, input logic po, input logic [7:0] d);
    @(negedge clk); f4.push = pu; f4.pop = po; f4.data_in = d;
    @(posedge clk); #1; f4.push = 1'b0; f4.pop = 1'b0;
  endtask

  task automatic op6(input logic pu, input logic po, input logic [7:0] d);
    @(negedge clk); f6.push = pu; f6.pop = po; f6.data_in = d;
    @(posedge clk); #1; f6.push = 1'b0; f6.pop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (f6.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", f6.empty); end
    checks++; if (f6.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", f6.full); end
    checks++; if (f6.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b expected 1", f6.almost_empty); end
    checks++; if (f6.almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b expected 0", f6.almost_full); end
    checks++; if (f6.count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", f6.count); end
    checks++; if (f6.overflow !== 1'b0 || f6.underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b%b expected 00", f6.overflow, f6.underflow); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_wrap;
    logic [7:0] exp_pop [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    for (int i = 0; i < 5; i++) op5(1'b1, 1'b0, 8'(8'h11 + i));
    checks++; if (f5.full !== 1'b1 || f5.count !== 3'd5) begin errors++; $display("FAIL wrap_fill: got full=%b count=%0d expected full=1 count=5", f5.full, f5.count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (f5.data_out !== exp_pop[i]) begin errors++; $display("FAIL wrap_pop%0d: got %h expected %h", i, f5.data_out, exp_pop[i]); end
      op5(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 3; i++) op5(1'b1, 1'b0, 8'(8'h16 + i));
    checks++; if (f5.full !== 1'b1 || f5.count !== 3'd5) begin errors++; $display("FAIL wrap_refill: got full=%b count=%0d expected full=1 count=5", f5.full, f5.count); end
    for (int i = 3; i < 8; i++) begin
      checks++; if (f5.data_out !== exp_pop[i]) begin errors++; $display("FAIL wrap_pop%0d: got %h expected %h", i, f5.data_out, exp_pop[i]); end
      op5(1'b0, 1'b1, 8'h00);
    end
    checks++; if (f5.empty !== 1'b1) begin errors++; $display("FAIL wrap_drain: got empty=%b expected 1", f5.empty); end
  endtask

  task automatic test_full_drop;
    logic [7:0] exp_tail [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
    for (int i = 0; i < 4; i++) op4(1'b1, 1'b0, 8'(8'hA0 + i));
    op4(1'b1, 1'b0, 8'hFF);
    checks++; if (f4.count !== 3'd4) begin errors++; $display("FAIL drop_count: got %0d expected 4", f4.count); end
    checks++; if (f4.data_out !== 8'hA0) begin errors++; $display("FAIL drop_head: got %h expected a0", f4.data_out); end
    checks++; if (f4.overflow !== ERR_EN) begin errors++; $display("FAIL drop_overflow: got %b expected %b", f4.overflow, ERR_EN); end
    op4(1'b1, 1'b1, 8'h55);
    checks++; if (f4.count !== 3'd4 || f4.full !== 1'b1) begin errors++; $display("FAIL simul_count: got count=%0d full=%b expected 4 1", f4.count, f4.full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (f4.data_out !== exp_tail[i]) begin errors++; $display("FAIL simul_pop%0d: got %h expected %h", i, f4.data_out, exp_tail[i]); end
      op4(1'b0, 1'b1, 8'h00);
    end
    checks++; if (f4.empty !== 1'b1) begin errors++; $display("FAIL simul_drain: got empty=%b expected 1", f4.empty); end
  endtask

  task automatic test_empty;
    op4(1'b0, 1'b1, 8'h00);
    checks++; if (f4.count !== 3'd0) begin errors++; $display("FAIL under_count: got %0d expected 0", f4.count); end
    checks++; if (f4.underflow !== ERR_EN) begin errors++; $display("FAIL under_flag: got %b expected %b", f4.underflow, ERR_EN); end
    op4(1'b1, 1'b1, 8'h3C);
    checks++; if (f4.count !== 3'd1) begin errors++; $display("FAIL nobypass_count: got %0d expected 1", f4.count); end
    checks++; if (f4.data_out !== 8'h3C) begin errors++; $display("FAIL nobypass_head: got %h expected 3c", f4.data_out); end
  endtask

  task automatic test_thresholds;
    logic af_up [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic ae_up [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic ae_dn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      op6(1'b1, 1'b0, 8'(8'h60 + i));
      checks++; if (f6.almost_full !== af_up[i] || f6.almost_empty !== ae_up[i]) begin errors++; $display("FAIL thr_push%0d: got af=%b ae=%b expected af=%b ae=%b", i + 1, f6.almost_full, f6.almost_empty, af_up[i], ae_up[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      op6(1'b0, 1'b1, 8'h00);
      checks++; if (f6.almost_full !== 1'b0 || f6.almost_empty !== ae_dn[i]) begin errors++; $display("FAIL thr_pop%0d: got af=%b ae=%b expected af=0 ae=%b", i + 1, f6.almost_full, f6.almost_empty, ae_dn[i]); end
    end
    checks++; if (f6.data_out !== 8'h64 || f6.count !== 3'd1) begin errors++; $display("FAIL thr_head: got %h/%0d expected 64/1", f6.data_out, f6.count); end
  endtask

  task automatic test_flush_reset;
    op6(1'b1, 1'b0, 8'h70);
    op6(1'b1, 1'b0, 8'h71);
    checks++; if (f6.count !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d expected 3", f6.count); end
    @(negedge clk); f6.flush = 1'b1; f6.push = 1'b1; f6.data_in = 8'h72;
    @(posedge clk); #1; f6.flush = 1'b0; f6.push = 1'b0;
    checks++; if (f6.count !== 3'd0 || f6.empty !== 1'b1 || f6.almost_empty !== 1'b1 || f6.almost_full !== 1'b0 || f6.full !== 1'b0) begin errors++; $display("FAIL flush_state: got count=%0d e=%b ae=%b af=%b f=%b expected 0 1 1 0 0", f6.count, f6.empty, f6.almost_empty, f6.almost_full, f6.full); end
    op6(1'b1, 1'b0, 8'h80);
    checks++; if (f6.data_out !== 8'h80 || f6.count !== 3'd1) begin errors++; $display("FAIL flush_after: got %h/%0d expected 80/1", f6.data_out, f6.count); end
    op6(1'b1, 1'b0, 8'h81);
    op6(1'b1, 1'b0, 8'h82);
    @(negedge clk); rst = 1'b1; f6.push = 1'b1; f6.pop = 1'b1; f6.data_in = 8'h83;
    @(posedge clk); #1; rst = 1'b0; f6.push = 1'b0; f6.pop = 1'b0;
    checks++; if (f6.count !== 3'd0 || f6.empty !== 1'b1 || f6.almost_empty !== 1'b1 || f6.almost_full !== 1'b0) begin errors++; $display("FAIL rst_mid: got count=%0d e=%b ae=%b af=%b expected 0 1 1 0", f6.count, f6.empty, f6.almost_empty, f6.almost_full); end
    op6(1'b1, 1'b0, 8'h90);
    checks++; if (f6.data_out !== 8'h90 || f6.count !== 3'd1) begin errors++; $display("FAIL rst_after: got %h/%0d expected 90/1", f6.data_out, f6.count); end
    // Error flags on the depth-4 instance are set from earlier scenarios; flush must clear them.
    op4(1'b0, 1'b1, 8'h00);
    op4(1'b0, 1'b1, 8'h00);
    checks++; if (f4.underflow !== ERR_EN) begin errors++; $display("FAIL err_sticky: got %b expected %b", f4.underflow, ERR_EN); end
    @(negedge clk); f4.flush = 1'b1;
    @(posedge clk); #1; f4.flush = 1'b0;
    checks++; if (f4.overflow !== 1'b0 || f4.underflow !== 1'b0 || f4.count !== 3'd0) begin errors++; $display("FAIL flush_err: got ov=%b uf=%b count=%0d expected 0 0 0", f4.overflow, f4.underflow, f4.count); end
  endtask

  initial begin
    f5.flush = 1'b0; f5.push = 1'b0; f5.pop = 1'b0; f5.data_in = '0;
    f4.flush = 1'b0; f4.push = 1'b0; f4.pop = 1'b0; f4.data_in = '0;
    f6.flush = 1'b0; f6.push = 1'b0; f6.pop = 1'b0; f6.data_in = '0;
    test_reset();
    test_wrap();
    test_full_drop();
    test_empty();
    test_thresholds();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
